// File: rtl/vid_pkg.sv
`default_nettype none
// ============================================================================
// Module      : vid_pkg
// Description : Shared video constants, 3x3 window indices and clog2 helper.
// Revision    : 1.0 - initial release
// ============================================================================
package vid_pkg;

  localparam int N_DEFAULT     = 8;
  localparam int H_MAX_DEFAULT = 1280;

  // Window element indices, k = 3*row + col (row 0 = oldest line)
  localparam int WIN_TL = 0;
  localparam int WIN_T  = 1;
  localparam int WIN_TR = 2;
  localparam int WIN_L  = 3;
  localparam int WIN_C  = 4;
  localparam int WIN_R  = 5;
  localparam int WIN_BL = 6;
  localparam int WIN_B  = 7;
  localparam int WIN_BR = 8;

  // Number of address bits needed to cover 'value' locations
  function automatic int clog2(input int value);
    int v;
    int r;
    r = 0;
    v = value - 1;
    while (v > 0) begin
      r = r + 1;
      v = v >> 1;
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/delay.sv
`default_nettype none
// ============================================================================
// Module      : delay
// Description : ce-gated shift-register delay line with synchronous reset.
// Revision    : 1.0 - initial release
// ============================================================================
module delay #(
  parameter int N     = 3,
  parameter int DELAY = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_ce,
  input  logic [N-1:0] i_din,
  output logic [N-1:0] o_dout
);

  logic [N-1:0] r_pipe [0:DELAY-1];

  // Shift the input through DELAY stages on every enabled clock
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int i = 0; i < DELAY; i++) begin
        r_pipe[i] <= '0;
      end
    end else if (i_ce) begin
      r_pipe[0] <= i_din;
      for (int i = 1; i < DELAY; i++) begin
        r_pipe[i] <= r_pipe[i-1];
      end
    end
  end

  assign o_dout = r_pipe[DELAY-1];

endmodule
`default_nettype wire

// File: rtl/line_ram.sv
`default_nettype none
// ============================================================================
// Module      : line_ram
// Description : Single-clock line buffer, separate read/write addresses,
//               read-first on address collision, all activity gated by ce.
// Revision    : 1.0 - initial release
// ============================================================================
module line_ram #(
  parameter int N      = 8,
  parameter int DEPTH  = 1280,
  parameter int ADDR_W = 11
) (
  input  logic              clk,
  input  logic              i_ce,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [N-1:0]      i_din,
  input  logic              i_re,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [N-1:0]      o_dout
);

  logic [N-1:0] r_mem [0:DEPTH-1];
  logic [N-1:0] r_dout;

  // Read-first port: the read returns the word present before this cycle's write
  always_ff @(posedge clk) begin
    if (i_ce) begin
      if (i_re) begin
        r_dout <= r_mem[i_raddr];
      end
      if (i_we) begin
        r_mem[i_waddr] <= i_din;
      end
    end
  end

  assign o_dout = r_dout;

endmodule
`default_nettype wire

// File: rtl/window_3x3.sv
`default_nettype none
// ============================================================================
// Module      : window_3x3
// Description : Streaming 3x3 neighbourhood generator. Two cascaded line RAMs
//               supply the previous lines; syncs are aligned via delay.
// Revision    : 1.0 - initial release
// ============================================================================
module window_3x3
  import vid_pkg::*;
#(
  parameter int N      = N_DEFAULT,
  parameter int H_MAX  = H_MAX_DEFAULT,
  parameter int ADDR_W = clog2(H_MAX)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic           ce,
  input  logic           de_in,
  input  logic           hsync_in,
  input  logic           vsync_in,
  input  logic [N-1:0]   pix_in,
  output logic [9*N-1:0] win,
  output logic           de_out,
  output logic           hsync_out,
  output logic           vsync_out,
  output logic           win_valid
);

  localparam logic [ADDR_W-1:0] c_COL_MAX = ADDR_W'(H_MAX - 1);

  // Stage 0: counters and edge detectors
  logic [ADDR_W-1:0] r_col;
  logic [1:0]        r_row;
  logic              r_vs_prev;
  logic              r_de_prev;
  logic              r_started;
  logic              w_vs_rise;
  logic              w_de_rise;
  logic              w_de_fall;
  logic [1:0]        w_row_cur;

  // Stage 1: registered pixel and tags, aligned with the RAM read data
  logic              r_de1;
  logic [N-1:0]      r_pix1;
  logic [1:0]        r_row1;
  logic [ADDR_W-1:0] r_col1;
  logic [N-1:0]      w_l1;
  logic [N-1:0]      w_l2;

  // Stage 2: window registers
  logic [N-1:0]      r_win [WIN_TL:WIN_BR];
  logic              r_valid;

  assign w_vs_rise = vsync_in & ~r_vs_prev;
  assign w_de_rise = de_in & ~r_de_prev;
  assign w_de_fall = ~de_in & r_de_prev;
  // A frame-start edge coinciding with a pixel makes that pixel row 0
  assign w_row_cur = w_vs_rise ? 2'd0 : r_row;

  // Column/row counters; rows only advance once a full line start has been
  // seen, so a line cut by reset is not counted
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_col     <= '0;
      r_row     <= '0;
      r_vs_prev <= 1'b0;
      r_de_prev <= 1'b1;
      r_started <= 1'b0;
    end else if (ce) begin
      r_vs_prev <= vsync_in;
      r_de_prev <= de_in;
      if (de_in) begin
        if (r_col != c_COL_MAX) begin
          r_col <= r_col + ADDR_W'(1);
        end
      end else begin
        r_col <= '0;
      end
      if (w_de_rise) begin
        r_started <= 1'b1;
      end
      if (w_vs_rise) begin
        r_row <= '0;
      end else if (w_de_fall && r_started && (r_row != 2'd3)) begin
        r_row <= r_row + 2'd1;
      end
    end
  end

  // L1 holds the previous line; its read-first output feeds L2 one stage later
  line_ram #(.N(N), .DEPTH(H_MAX), .ADDR_W(ADDR_W)) u_l1 (
    .clk     (clk),
    .i_ce    (ce),
    .i_we    (de_in),
    .i_waddr (r_col),
    .i_din   (pix_in),
    .i_re    (de_in),
    .i_raddr (r_col),
    .o_dout  (w_l1)
  );

  line_ram #(.N(N), .DEPTH(H_MAX), .ADDR_W(ADDR_W)) u_l2 (
    .clk     (clk),
    .i_ce    (ce),
    .i_we    (r_de1),
    .i_waddr (r_col1),
    .i_din   (w_l1),
    .i_re    (de_in),
    .i_raddr (r_col),
    .o_dout  (w_l2)
  );

  // Stage 1: register the newest pixel and its position tags
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_de1  <= 1'b0;
      r_pix1 <= '0;
      r_row1 <= '0;
      r_col1 <= '0;
    end else if (ce) begin
      r_de1  <= de_in;
      r_pix1 <= pix_in;
      r_row1 <= w_row_cur;
      r_col1 <= r_col;
    end
  end

  // Stage 2: shift the new column into the window, older columns move left
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      for (int k = WIN_TL; k <= WIN_BR; k++) begin
        r_win[k] <= '0;
      end
      r_valid <= 1'b0;
    end else if (ce) begin
      r_valid <= r_de1 && (r_row1 >= 2'd2) && (r_col1 >= ADDR_W'(2));
      if (r_de1) begin
        r_win[WIN_TL] <= r_win[WIN_T];
        r_win[WIN_T]  <= r_win[WIN_TR];
        r_win[WIN_TR] <= w_l2;
        r_win[WIN_L]  <= r_win[WIN_C];
        r_win[WIN_C]  <= r_win[WIN_R];
        r_win[WIN_R]  <= w_l1;
        r_win[WIN_BL] <= r_win[WIN_B];
        r_win[WIN_B]  <= r_win[WIN_BR];
        r_win[WIN_BR] <= r_pix1;
      end
    end
  end

  for (genvar k = WIN_TL; k <= WIN_BR; k++) begin : g_win_pack
    assign win[k*N +: N] = r_win[k];
  end

  assign win_valid = r_valid;

  delay #(.N(3), .DELAY(2)) u_sync_delay (
    .clk    (clk),
    .rst_n  (rst_n),
    .i_ce   (ce),
    .i_din  ({vsync_in, hsync_in, de_in}),
    .o_dout ({vsync_out, hsync_out, de_out})
  );

endmodule
`default_nettype wire

// File: doc/window_3x3.md
# window_3x3

Streaming 3x3 neighbourhood generator feeding the Gaussian kernel stage. Accepts a raster pixel stream with video syncs. Buffers the two previous lines in block RAM and emits a full 3x3 window each pixel clock. The sync and enable signals are aligned to the window through the existing `delay` block, so the convolution stage and its downstream `delay` alignment see a consistent stream.

## Interface
- `N`, 8, pixel width in bits
- `H_MAX`, 1280, maximum active pixels per line (line RAM depth)
- `ADDR_W`, 11, column counter/RAM address width, must satisfy 2^ADDR_W >= H_MAX
- `clk`  in  1  pixel clock, all logic on rising edge
- `rst_n`  in  1  synchronous, active-low reset
- `ce`  in  1  clock enable; when low all state, including RAM writes, is frozen
- `de_in`  in  1  active-video flag for `pix_in`
- `hsync_in`  in  1  horizontal sync, passed through
- `vsync_in`  in  1  vertical sync; a rising edge starts a new frame
- `pix_in`  in  N  input pixel
- `win`  out  9*N  window; element k = `win[k*N +: N]`, k = 3*row + col; row 0 = oldest line, col 0 = oldest pixel, k=8 = newest pixel
- `de_out`, `hsync_out`, `vsync_out`  out  1 each  input syncs delayed to match `win`
- `win_valid`  out  1  all nine window elements belong to the current frame

## Operation
- Column counter `col` counts `de_in`=1 cycles from 0 and clears on `de_in` falling edge. It saturates at H_MAX-1. Pixels beyond H_MAX-1 overwrite address H_MAX-1; this behaviour is defined but unsupported.
- Row counter `row` increments on each `de_in` falling edge and saturates at 3. It clears when a `vsync_in` rising edge is detected.
- Two line RAMs, L1 and L2, depth H_MAX, width N, read-first. On each `ce`·`de_in` cycle at address `col`:
  - write `pix_in` to L1;
  - write L1's old word to L2 (cascade);
  - read both old words.
- Window: three column shift registers, each 3 deep. On each `ce`·`de` cycle (stage 2), the vector {L2 out, L1 out, registered pix} shifts in at col 2, and the old col 2 moves to col 1, then to col 0.
- `win_valid` = `de_out` AND (row of newest pixel >= 2) AND (col of newest pixel >= 2). The row and col tags are pipelined with the data.
- All inputs are sampled only when `ce`=1. With `ce`=0, outputs hold their values.
- No backpressure. The stream is free-running under `ce`.

## Timing
- Latency: 2 `ce`-cycles from `pix_in`/syncs to `win` element 8 / `*_out`.
- Reset (`rst_n`=0 at a rising edge, regardless of `ce`):
  - `win`=0, `de_out`=`hsync_out`=`vsync_out`=0, `win_valid`=0;
  - `col`=0, `row`=0, vsync edge detector cleared.
- RAM contents are not cleared. Stale data is masked by `win_valid`.
- Reset mid-line: the next line after release is treated as row 0 and `win_valid` stays 0 for the first two lines.
- `vsync_in` rising edge in the same cycle as `de_in`=1: the row clears first and that pixel is row 0.
- `ce` toggling mid-line: the result is identical to the same stream with the `ce`=0 cycles removed.

## Structure
- Shared package `vid_pkg`:
  - default `N`, `H_MAX`;
  - window index constants (`WIN_TL`=0 … `WIN_C`=4 … `WIN_BR`=8);
  - function `clog2` for `ADDR_W`.
- Sub-module `line_ram`: single-clock, read-first, `ce`-gated RAM, instantiated twice.
- Sync alignment reuses the existing `delay` with N=3, DELAY=2.

## Test plan
- Reset: hold `rst_n`=0 for 3 cycles with random inputs. Required: all outputs 0 and `win_valid`=0.
- 8x4 frame, `pix_in` = 16*row + col. At row 2, col 2, exactly 2 cycles after input:
  - `win` = {0x00,0x01,0x02,0x10,0x11,0x12,0x20,0x21,0x22};
  - `win_valid`=1 for cols 2..7 of rows 2..3 only (12 assertions).
- Same frame with `ce` deasserted every 3rd cycle. Required: `win` sequence and `win_valid` sequence identical after removing `ce`=0 cycles.
- Two back-to-back frames with a `vsync_in` pulse between them. Required: `win_valid`=0 for the first two lines of frame 2, with no frame-1 pixels in any valid window.
- Reset asserted mid-row 3 of a frame. Required: the next two lines produce `win_valid`=0, and the third line produces valid windows with correct contents.
- Line of H_MAX=16 (small parameter). Required: col 15 window correct, and `col` clears on the `de_in` fall.
